// File: rtl/comparator_bank.sv
// comparator_bank: multi-channel registered compare-match unit.
// A free-running count is compared against CHANNELS compare values. Each
// channel has a shadow/active pair of registers, a match mode, and one-shot
// arming. Each channel produces a one-cycle match pulse and a sticky flag.
//
// Handshake note: there are no valid/ready pairs. wr_en, load, arm and clr are
// single-cycle strobes that are sampled on the rising clock edge. Every output
// is registered and changes one cycle after the inputs that caused it.
// The per-channel FSM state is the 'armed' output itself (IDLE=0, ARMED=1).
module comparator_bank #(
   parameter int WIDTH    = 24,
   parameter int CHANNELS = 4,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [WIDTH-1:0]    value,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_cmp,
   input  logic [1:0]          wr_mode,
   input  logic                load,
   input  logic [CHANNELS-1:0] arm,
   input  logic [CHANNELS-1:0] clr,
   output logic [CHANNELS-1:0] agb,
   output logic [CHANNELS-1:0] aeb,
   output logic [CHANNELS-1:0] alb,
   output logic [CHANNELS-1:0] match_pulse,
   output logic [CHANNELS-1:0] match_flag,
   output logic [CHANNELS-1:0] armed
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_EQ    = 2'b01,
      MODE_GE    = 2'b10,
      MODE_CROSS = 2'b11
   } mode_e;

   typedef enum logic {
      CH_IDLE  = 1'b0,
      CH_ARMED = 1'b1
   } ch_state_e;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] sh_cmp_q, sh_cmp_d;
      logic [WIDTH-1:0] act_cmp_q, act_cmp_d;
      mode_e            sh_mode_q, sh_mode_d;
      mode_e            act_mode_q, act_mode_d;
      ch_state_e        state_q, state_d;
      mode_e            next_mode;
      logic             flag_q, flag_d;
      logic             pulse_q;
      logic             agb_q, aeb_q, alb_q;
      logic             cmp_gt, cmp_eq, cmp_lt;
      logic             wr_hit, cond, fire;

      // wr_ch values at or above CHANNELS never match any generated index.
      // Because of that, out-of-range writes drop out without an explicit range check.
      assign wr_hit = wr_en && (wr_ch == CH_W'(i));

      // Unsigned magnitude compare of the live count against the active value.
      assign cmp_gt = value >  act_cmp_q;
      assign cmp_eq = value == act_cmp_q;
      assign cmp_lt = value <  act_cmp_q;

      // Shadow/active transfer. load moves the old shadow into the active
      // register. A write in the same cycle updates only the shadow.
      always_comb begin
         sh_cmp_d   = sh_cmp_q;
         sh_mode_d  = sh_mode_q;
         act_cmp_d  = act_cmp_q;
         act_mode_d = act_mode_q;
         if (load) begin
            act_cmp_d  = sh_cmp_q;
            act_mode_d = sh_mode_q;
         end
         if (wr_hit) begin
            sh_cmp_d  = wr_cmp;
            sh_mode_d = mode_e'(wr_mode);
         end
      end

      // Fire decision on the current sample, using the pre-load active mode.
      // Crossing mode uses the registered alb from the previous sample.
      always_comb begin
         cond = 1'b0;
         case (act_mode_q)
            MODE_EQ:    cond = cmp_eq;
            MODE_GE:    cond = !cmp_lt;
            MODE_CROSS: cond = alb_q && !cmp_lt;
            default:    cond = 1'b0;
         endcase
         fire = (state_q == CH_ARMED) && cond;
      end

      // One-shot arming FSM. An arm request (from arm or load) takes priority
      // over the disarm that a fire in the same cycle would cause.
      always_comb begin
         state_d   = state_q;
         next_mode = load ? sh_mode_q : act_mode_q;
         case (state_q)
            CH_IDLE: begin
               if ((load || arm[i]) && next_mode != MODE_OFF) state_d = CH_ARMED;
            end
            CH_ARMED: begin
               if ((load || arm[i]) && next_mode != MODE_OFF) state_d = CH_ARMED;
               else if (load || fire)                         state_d = CH_IDLE;
            end
            default: state_d = CH_IDLE;
         endcase
      end

      // Sticky flag. A fire takes priority over a write-one-to-clear in the same cycle.
      assign flag_d = fire || (flag_q && !clr[i]);

      // Channel register bank, cleared asynchronously.
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            sh_cmp_q   <= '0;
            sh_mode_q  <= MODE_OFF;
            act_cmp_q  <= '0;
            act_mode_q <= MODE_OFF;
            state_q    <= CH_IDLE;
            flag_q     <= 1'b0;
            pulse_q    <= 1'b0;
            agb_q      <= 1'b0;
            aeb_q      <= 1'b0;
            alb_q      <= 1'b0;
         end else begin
            sh_cmp_q   <= sh_cmp_d;
            sh_mode_q  <= sh_mode_d;
            act_cmp_q  <= act_cmp_d;
            act_mode_q <= act_mode_d;
            state_q    <= state_d;
            flag_q     <= flag_d;
            pulse_q    <= fire;
            agb_q      <= cmp_gt;
            aeb_q      <= cmp_eq;
            alb_q      <= cmp_lt;
         end
      end

      assign agb[i]         = agb_q;
      assign aeb[i]         = aeb_q;
      assign alb[i]         = alb_q;
      assign match_pulse[i] = pulse_q;
      assign match_flag[i]  = flag_q;
      assign armed[i]       = (state_q == CH_ARMED);
   end

endmodule

// File: tb/tb_comparator_bank.sv
// tb_comparator_bank: scenario tasks plus a randomized run.
// Every task is checked against a per-channel behavioural model of the compare-match rules.
module tb_comparator_bank;
   localparam int WIDTH    = 24;
   localparam int CHANNELS = 4;
   localparam int CH_W     = 2;
   localparam int OBS_W    = 6 * CHANNELS;

   // Clock and reset.
   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   logic [WIDTH-1:0]    value;
   logic                wr_en;
   logic [CH_W-1:0]     wr_ch;
   logic [WIDTH-1:0]    wr_cmp;
   logic [1:0]          wr_mode;
   logic                load;
   logic [CHANNELS-1:0] arm;
   logic [CHANNELS-1:0] clr;
   logic [CHANNELS-1:0] agb, aeb, alb, match_pulse, match_flag, armed;

   int n_checks = 0;
   int n_fail   = 0;

   comparator_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
      .clk(clk), .n_rst(n_rst), .value(value),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_cmp(wr_cmp), .wr_mode(wr_mode),
      .load(load), .arm(arm), .clr(clr),
      .agb(agb), .aeb(aeb), .alb(alb),
      .match_pulse(match_pulse), .match_flag(match_flag), .armed(armed)
   );

   // Behavioural model: one record per channel, advanced once per clock.
   logic [WIDTH-1:0] m_sh_cmp  [CHANNELS];
   logic [WIDTH-1:0] m_act_cmp [CHANNELS];
   logic [1:0]       m_sh_mode [CHANNELS];
   logic [1:0]       m_act_mode[CHANNELS];
   bit m_armed[CHANNELS], m_flag[CHANNELS], m_pulse[CHANNELS];
   bit m_gt[CHANNELS], m_eq[CHANNELS], m_lt[CHANNELS];

   function automatic void model_reset();
      for (int c = 0; c < CHANNELS; c++) begin
         m_sh_cmp[c] = '0;  m_act_cmp[c] = '0;
         m_sh_mode[c] = '0; m_act_mode[c] = '0;
         m_armed[c] = 0; m_flag[c] = 0; m_pulse[c] = 0;
         m_gt[c] = 0; m_eq[c] = 0; m_lt[c] = 0;
      end
   endfunction

   function automatic void model_step();
      bit hit, fire;
      logic [1:0] nm;
      for (int c = 0; c < CHANNELS; c++) begin
         case (m_act_mode[c])
            2'd1:    hit = (value == m_act_cmp[c]);
            2'd2:    hit = (value >= m_act_cmp[c]);
            2'd3:    hit = m_lt[c] && (value >= m_act_cmp[c]);
            default: hit = 0;
         endcase
         fire       = m_armed[c] && hit;
         m_pulse[c] = fire;
         m_flag[c]  = fire || (m_flag[c] && !clr[c]);
         nm         = load ? m_sh_mode[c] : m_act_mode[c];
         m_armed[c] = m_armed[c] && !fire;
         if (load) m_armed[c] = (m_sh_mode[c] != 2'd0);
         if (arm[c] && nm != 2'd0) m_armed[c] = 1;
         m_gt[c] = value >  m_act_cmp[c];
         m_eq[c] = value == m_act_cmp[c];
         m_lt[c] = value <  m_act_cmp[c];
         if (load) begin
            m_act_cmp[c]  = m_sh_cmp[c];
            m_act_mode[c] = m_sh_mode[c];
         end
         if (wr_en && wr_ch == CH_W'(c)) begin
            m_sh_cmp[c]  = wr_cmp;
            m_sh_mode[c] = wr_mode;
         end
      end
   endfunction

   function automatic logic [OBS_W-1:0] exp_vec();
      logic [OBS_W-1:0] v;
      for (int c = 0; c < CHANNELS; c++) begin
         v[5*CHANNELS+c] = m_gt[c];
         v[4*CHANNELS+c] = m_eq[c];
         v[3*CHANNELS+c] = m_lt[c];
         v[2*CHANNELS+c] = m_pulse[c];
         v[1*CHANNELS+c] = m_flag[c];
         v[c]            = m_armed[c];
      end
      return v;
   endfunction

   function automatic logic [OBS_W-1:0] obs_vec();
      return {agb, aeb, alb, match_pulse, match_flag, armed};
   endfunction

   // Driver tasks: inputs change 1 time unit after the rising edge.
   task automatic tick();
      if (!n_rst) model_reset();
      else        model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_ch = '0; wr_cmp = '0; wr_mode = 2'd0;
      load = 0; arm = '0; clr = '0;
   endtask

   task automatic do_write(input int ch, input logic [WIDTH-1:0] cmp, input logic [1:0] mode);
      wr_en = 1; wr_ch = CH_W'(ch); wr_cmp = cmp; wr_mode = mode;
      tick();
      wr_en = 0;
   endtask

   task automatic do_load();
      load = 1;
      tick();
      load = 0;
   endtask

   task automatic test_reset();
      n_rst = 0;
      idle_inputs();
      value = '0;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         value = WIDTH'($urandom);
         tick();
         n_checks++;
         if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected 0", obs_vec());
         end
      end
      n_rst = 1;
      value = '0;
      tick();
      n_checks++;
      if (aeb !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_first_aeb: got %h expected f", aeb);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_first_edge: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_equal_oneshot();
      int pulses;
      int pulse_at;
      do_write(0, 24'h100, 2'd1);
      value = 24'h0F0;
      do_load();
      for (int pass = 0; pass < 2; pass++) begin
         pulses = 0; pulse_at = -1;
         for (int v = 'hF0; v <= 'h10F; v++) begin
            value = WIDTH'(v);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL equal_ramp: got %h expected %h", obs_vec(), exp_vec());
            end
            if (match_pulse[0]) begin pulses++; pulse_at = v; end
         end
         n_checks++;
         if (pulses != ((pass == 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL equal_pulse_count: got %0d expected %0d (pass %0d)", pulses, (pass == 0) ? 1 : 0, pass);
         end
         if (pass == 0) begin
            n_checks++;
            if (pulse_at != 'h100) begin
               n_fail++;
               $display("FAIL equal_pulse_value: got %h expected 100", pulse_at);
            end
            n_checks++;
            if (match_flag[0] !== 1'b1 || armed[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL equal_flag_armed: got flag %b armed %b expected 1 0", match_flag[0], armed[0]);
            end
         end
      end
   endtask

   task automatic test_crossing();
      logic [WIDTH-1:0] steps [3];
      steps[0] = 24'h0FA; steps[1] = 24'h0FD; steps[2] = 24'h103;
      do_write(1, 24'h100, 2'd3);
      do_write(2, 24'h100, 2'd1);
      value = 24'h0F0;
      do_load();
      for (int k = 0; k < 3; k++) begin
         value = steps[k];
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL crossing_step: got %h expected %h", obs_vec(), exp_vec());
         end
         n_checks++;
         if (match_pulse !== ((k == 2) ? 4'b0010 : 4'b0000)) begin
            n_fail++;
            $display("FAIL crossing_pulse: got %b expected %b at step %0d", match_pulse, (k == 2) ? 4'b0010 : 4'b0000, k);
         end
      end
   endtask

   task automatic test_shadow();
      int pulses;
      do_write(0, 24'h050, 2'd1);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            value = 24'h040;
            do_load();
         end
         pulses = 0;
         for (int v = 'h40; v <= 'h5F; v++) begin
            value = WIDTH'(v);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL shadow_ramp: got %h expected %h", obs_vec(), exp_vec());
            end
            if (match_pulse[0]) pulses++;
         end
         n_checks++;
         if (pulses != pass) begin
            n_fail++;
            $display("FAIL shadow_pulse_count: got %0d expected %0d (pass %0d)", pulses, pass, pass);
         end
      end
   endtask

   task automatic test_collisions();
      int pulses;
      // Clear the flag, re-arm ch0 (equal 0x050), then fire together with clr.
      value = 24'h040;
      clr = 4'b0001; tick(); clr = '0;
      n_checks++;
      if (match_flag[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_flag: got %b expected 0", match_flag[0]);
      end
      arm = 4'b0001; tick(); arm = '0;
      value = 24'h050; clr = 4'b0001;
      tick();
      clr = '0;
      n_checks++;
      if (match_pulse[0] !== 1'b1 || match_flag[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL fire_vs_clr: got pulse %b flag %b expected 1 1", match_pulse[0], match_flag[0]);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL fire_vs_clr_all: got %h expected %h", obs_vec(), exp_vec());
      end
      // Greater-or-equal with value held above cmp and arm held.
      do_write(0, 24'h080, 2'd2);
      value = 24'h010;
      do_load();
      value = 24'h090; arm = 4'b0001;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL arm_vs_fire: got %h expected %h", obs_vec(), exp_vec());
         end
         if (match_pulse[0] && armed[0]) pulses++;
      end
      arm = '0;
      n_checks++;
      if (pulses != 5) begin
         n_fail++;
         $display("FAIL arm_hold_pulses: got %0d expected 5", pulses);
      end
   endtask

   task automatic test_wrap();
      int pulses = 0;
      logic [WIDTH-1:0] steps [3];
      steps[0] = 24'hFFFFFE; steps[1] = 24'hFFFFFF; steps[2] = 24'h000020;
      do_write(3, 24'h000010, 2'd3);
      value = 24'hFFFFF0;
      do_load();
      for (int k = 0; k < 3; k++) begin
         value = steps[k];
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_step: got %h expected %h", obs_vec(), exp_vec());
         end
         if (match_pulse[3]) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL wrap_no_cross: got %0d expected 0", pulses);
      end
   endtask

   task automatic test_async_reset();
      int pulses = 0;
      do_write(0, 24'h200, 2'd1);
      value = 24'h1F0;
      do_load();
      for (int v = 'h1F1; v <= 'h1F8; v++) begin
         value = WIDTH'(v);
         tick();
      end
      n_checks++;
      if (armed[0] !== 1'b1 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL async_pre: got %h expected %h", obs_vec(), exp_vec());
      end
      #2 n_rst = 0;
      #1;
      model_reset();
      n_checks++;
      if (obs_vec() !== '0) begin
         n_fail++;
         $display("FAIL async_immediate: got %h expected 0", obs_vec());
      end
      @(posedge clk); #1;
      tick();
      n_rst = 1;
      for (int v = 'h1F9; v <= 'h20F; v++) begin
         value = WIDTH'(v);
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_after: got %h expected %h", obs_vec(), exp_vec());
         end
         if (match_pulse != '0) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL async_no_pulse: got %0d expected 0", pulses);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_ch   = CH_W'($urandom_range(0, CHANNELS - 1));
         wr_cmp  = WIDTH'($urandom_range(0, 40));
         wr_mode = 2'($urandom_range(0, 3));
         load    = ($urandom_range(0, 7) == 0);
         arm     = ($urandom_range(0, 3) == 0) ? CHANNELS'($urandom) : '0;
         clr     = ($urandom_range(0, 3) == 0) ? CHANNELS'($urandom) : '0;
         case ($urandom_range(0, 9))
            0:       value = WIDTH'($urandom);
            1, 2, 3: value = value + WIDTH'($urandom_range(1, 5));
            default: value = WIDTH'($urandom_range(0, 40));
         endcase
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cycle_%0d: got %h expected %h", k, obs_vec(), exp_vec());
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_equal_oneshot();
      test_crossing();
      test_shadow();
      test_collisions();
      test_wrap();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
